// File: rtl/demux_1to3.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1to3
//  Description : Buffered 1-to-3 stream distributor. Each lane has its own
//                2-entry FIFO; illegal select 3 is consumed, dropped and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1to3 #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data [3],
    output logic [2:0]            out_val,
    input  logic [2:0]            out_rdy,
    input  logic                  err_clr,
    output logic                  err_sel,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam int   c_LANES   = 3;
    localparam logic [1:0] c_SEL_ILLEGAL = 2'd3;

    logic [c_LANES-1:0]   w_lane_full;
    logic                 w_accept;
    logic                 w_drop;
    logic                 r_err_sel;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    // Ready looks only at the targeted lane's occupancy, never at out_rdy.
    always_comb begin
        in_rdy = 1'b1;
        case (in_sel)
            2'd0:    in_rdy = ~w_lane_full[0];
            2'd1:    in_rdy = ~w_lane_full[1];
            2'd2:    in_rdy = ~w_lane_full[2];
            default: in_rdy = 1'b1;
        endcase
    end

    assign w_accept = in_val && in_rdy;
    assign w_drop   = w_accept && (in_sel == c_SEL_ILLEGAL);

    genvar gi;
    generate
        for (gi = 0; gi < c_LANES; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] r_mem [2];
            logic                  r_rd_ptr;
            logic                  r_wr_ptr;
            logic [1:0]            r_cnt;
            logic                  w_push;
            logic                  w_pop;

            assign w_push = w_accept && (in_sel == 2'(gi));
            assign w_pop  = (r_cnt != 2'd0) && out_rdy[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[0] <= '0;
                    r_mem[1] <= '0;
                    r_rd_ptr <= 1'b0;
                    r_wr_ptr <= 1'b0;
                    r_cnt    <= 2'd0;
                end else begin
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= in_data;
                        r_wr_ptr        <= ~r_wr_ptr;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= ~r_rd_ptr;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_cnt <= r_cnt + 2'd1;
                        2'b01:   r_cnt <= r_cnt - 2'd1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            assign w_lane_full[gi] = (r_cnt == 2'd2);
            assign out_val[gi]     = (r_cnt != 2'd0);
            assign out_data[gi]    = r_mem[r_rd_ptr];
        end
    endgenerate

    // A drop in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sel  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_err_sel <= 1'b1;
            end else if (err_clr) begin
                r_err_sel <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != {CNT_WIDTH{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign err_sel  = r_err_sel;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1to3
//  Description : Scoreboard bench for demux_1to3; lane queues model the FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] out_data [3];
    logic [2:0] out_val;
    logic [2:0] out_rdy;
    logic       err_clr;
    logic       err_sel;
    logic [7:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q [3][$];
    logic       m_err;
    logic [7:0] m_drop;

    demux_1to3 #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_val(in_val), .in_rdy(in_rdy), .out_data(out_data),
        .out_val(out_val), .out_rdy(out_rdy), .err_clr(err_clr),
        .err_sel(err_sel), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: compare at negedge, then advance on the coming posedge.
    always @(negedge clk) begin
        logic exp_rdy;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) q[i].delete();
            m_err  = 1'b0;
            m_drop = 8'd0;
            check("rst_out_val", 32'(out_val), 32'd0);
            check("rst_err_sel", 32'(err_sel), 32'd0);
            check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("out_val%0d", i), 32'(out_val[i]), 32'(q[i].size() != 0));
                if (q[i].size() != 0)
                    check($sformatf("out_data%0d", i), 32'(out_data[i]), 32'(q[i][0]));
            end
            exp_rdy = (in_sel == 2'd3) ? 1'b1 : (q[in_sel].size() < 2);
            check("in_rdy", 32'(in_rdy), 32'(exp_rdy));
            check("err_sel", 32'(err_sel), 32'(m_err));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            for (int i = 0; i < 3; i++)
                if (q[i].size() != 0 && out_rdy[i]) void'(q[i].pop_front());
            if (in_val && exp_rdy && in_sel != 2'd3) begin
                q[in_sel].push_back(in_data);
            end
            if (in_val && in_sel == 2'd3) begin
                m_err = 1'b1;
                if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            end else if (err_clr) begin
                m_err = 1'b0;
            end
        end
    end

    // Drive one word and hold it until accepted; returns stall cycles.
    task automatic send(input logic [7:0] d, input logic [1:0] s, output int waits);
        logic acc;
        waits   = 0;
        in_val  = 1'b1;
        in_data = d;
        in_sel  = s;
        do begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end while (!acc && waits < 50);
        if (!acc) check("send_timeout", 32'(waits), 32'd0);
        in_val = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_done", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
    endtask

    initial begin
        int w;
        int stalls;
        rst_n = 1'b0; in_data = 8'd0; in_sel = 2'd0; in_val = 1'b0;
        out_rdy = 3'b111; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back one word per lane
        stalls = 0;
        send(8'hA5, 2'd0, w); stalls += w;
        send(8'h3C, 2'd1, w); stalls += w;
        send(8'h7E, 2'd2, w); stalls += w;
        check("t1_no_stall", 32'(stalls), 32'd0);
        drain();

        // Lane 0 backpressure and in-order release
        out_rdy[0] = 1'b0;
        send(8'h11, 2'd0, w);
        send(8'h22, 2'd0, w);
        in_val = 1'b1; in_data = 8'h33; in_sel = 2'd0;
        @(negedge clk);
        check("t2_full_rdy", 32'(in_rdy), 32'd0);
        @(posedge clk); #1;
        out_rdy[0] = 1'b1;
        send(8'h33, 2'd0, w);
        drain();

        // Steady stream through a lane holding one word
        out_rdy[0] = 1'b0;
        send(8'h40, 2'd0, w);
        out_rdy[0] = 1'b1;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(8'h41 + 8'(i), 2'd0, w);
            stalls += w;
        end
        check("t3_no_bubble", 32'(stalls), 32'd0);
        drain();

        // Illegal select handling and error clear
        send(8'hFF, 2'd3, w);
        send(8'hFF, 2'd3, w);
        @(negedge clk);
        check("t4_err_set", 32'(err_sel), 32'd1);
        check("t4_drop2", 32'(drop_cnt), 32'd2);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("t4_err_clr", 32'(err_sel), 32'd0);
        check("t4_drop_kept", 32'(drop_cnt), 32'd2);
        @(posedge clk); #1;
        err_clr = 1'b1;
        send(8'h00, 2'd3, w);
        err_clr = 1'b0;
        @(negedge clk);
        check("t4_set_wins", 32'(err_sel), 32'd1);
        @(posedge clk); #1;

        // Saturation of drop counter
        in_val = 1'b1; in_sel = 2'd3;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(i);
            @(posedge clk); #1;
        end
        in_val = 1'b0;
        @(negedge clk);
        check("t5_saturate", 32'(drop_cnt), 32'hFF);
        @(posedge clk); #1;

        // Asynchronous reset with full lanes
        out_rdy = 3'b000;
        for (int i = 0; i < 6; i++) send(8'h80 + 8'(i), 2'(i % 3), w);
        @(negedge clk);
        check("t6_full", 32'(out_val), 32'h7);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", 32'(out_val), 32'd0);
        check("t6_async_drop", 32'(drop_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_rdy = 3'b111;
        send(8'h5A, 2'd1, w);
        #1;
        check("t6_fresh_val", 32'(out_val), 32'h2);
        check("t6_fresh_data", 32'(out_data[1]), 32'h5A);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
